// File: rtl/optical_flow_pkg.sv
// Shared constants and helpers for the optical-flow filter blocks.
// Holds the binomial smoothing taps and the accumulator sizing rule.
// Pure declarations: no logic, no state.
package optical_flow_pkg;

   // 1-4-6-4-1 binomial taps; the separable 5x5 product totals 256.
   localparam int unsigned BINOM_W [5] = '{1, 4, 6, 4, 1};

   // Accumulator width for a 5x5 weighted sum: 8 guard bits cover a gain of 256.
   function automatic int acc_width(input int data_width);
      return data_width + 8;
   endfunction

endpackage

// File: rtl/window_sum_5x5.sv
// Purpose: 5x5 window sum (box, or binomial when WINDOW_SUM_WEIGHT_EN is defined), shift, saturate, tag position.
// Latency: 3 cycles window_valid -> sum_valid (row sums, total, shift+clip), one window per cycle.
// Backpressure: none; invalid cycles travel as bubbles and outputs hold between valid results.
module window_sum_5x5
   import optical_flow_pkg::*;
#(
   parameter int WIDTH      = 320,
   parameter int HEIGHT     = 240,
   parameter int DATA_WIDTH = 12,
   parameter int OUT_WIDTH  = 16,
   parameter int SHIFT      = 0
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic signed [DATA_WIDTH-1:0]  window [5][5],
   input  logic                          window_valid,
   output logic signed [OUT_WIDTH-1:0]   sum_out,
   output logic                          sum_valid,
   output logic                          sat,
   output logic [$clog2(WIDTH)-1:0]      out_col,
   output logic [$clog2(HEIGHT)-1:0]     out_row,
   output logic                          sof,
   output logic                          eol,
   output logic                          eof
);

   localparam int ACC_W = acc_width(DATA_WIDTH);
   localparam int EXT_W = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;
   localparam int CW    = $clog2(WIDTH);
   localparam int RW    = $clog2(HEIGHT);

   localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 5);
   localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 5);

   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [EXT_W-1:0] ext_t;

   localparam ext_t SAT_MAX = ext_t'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
   localparam ext_t SAT_MIN = ext_t'(-(64'sd1 <<< (OUT_WIDTH - 1)));

`ifdef WINDOW_SUM_WEIGHT_EN
   localparam int unsigned TAP_W [5] = BINOM_W;
`else
   localparam int unsigned TAP_W [5] = '{1, 1, 1, 1, 1};
`endif

   // Multiply by one of the tap values {1,4,6} with shifts and adds only.
   // Row taps are applied to the column-weighted row sum, so the 2-D weights
   // w[r]*w[c] come out without any multiplier.
   function automatic acc_t scale(input acc_t x, input int unsigned w);
      case (w)
         32'd4:   return x <<< 2;
         32'd6:   return (x <<< 2) + (x <<< 1);
         default: return x;
      endcase
   endfunction

   // Stage registers
   acc_t  row_d [5];
   acc_t  row_q [5];
   acc_t  total_d;
   acc_t  total_q;
   logic  v1;
   logic  v2;
   ext_t  shifted;
   logic  [OUT_WIDTH-1:0] clip_d;
   logic  clip_sat;
   logic  [CW-1:0] col_cnt;
   logic  [RW-1:0] row_cnt;

   // S1 combinational: column-weighted sum of each row, then row weight.
   always_comb begin
      for (int r = 0; r < 5; r++) begin
         row_d[r] = '0;
         for (int c = 0; c < 5; c++) begin
            row_d[r] = row_d[r] + scale(acc_t'(window[r][c]), TAP_W[c]);
         end
         row_d[r] = scale(row_d[r], TAP_W[r]);
      end
   end

   // S1/S2 datapath: no reset needed, the valid pipe qualifies the data.
   always_ff @(posedge clk) begin
      row_q   <= row_d;
      total_q <= total_d;
   end

   // S2 combinational: add the five row sums.
   always_comb begin
      total_d = '0;
      for (int r = 0; r < 5; r++) begin
         total_d = total_d + row_q[r];
      end
   end

   // Valid shift register; reset flushes anything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         v1 <= window_valid;
         v2 <= v1;
      end
   end

   // S3 combinational: arithmetic shift (floors) then clip to the output range.
   always_comb begin
      shifted  = ext_t'(total_q) >>> SHIFT;
      clip_sat = 1'b0;
      clip_d   = shifted[OUT_WIDTH-1:0];
      if (shifted > SAT_MAX) begin
         clip_d   = SAT_MAX[OUT_WIDTH-1:0];
         clip_sat = 1'b1;
      end else if (shifted < SAT_MIN) begin
         clip_d   = SAT_MIN[OUT_WIDTH-1:0];
         clip_sat = 1'b1;
      end
   end

   // S3 registers: result, flags and position; everything holds on bubbles.
   // col_cnt/row_cnt track the position the next valid result will carry.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_valid <= 1'b0;
         sum_out   <= '0;
         sat       <= 1'b0;
         sof       <= 1'b0;
         eol       <= 1'b0;
         eof       <= 1'b0;
         out_col   <= '0;
         out_row   <= '0;
         col_cnt   <= '0;
         row_cnt   <= '0;
      end else begin
         sum_valid <= v2;
         if (v2) begin
            sum_out <= clip_d;
            sat     <= clip_sat;
            out_col <= col_cnt;
            out_row <= row_cnt;
            sof     <= (col_cnt == '0) && (row_cnt == '0);
            eol     <= (col_cnt == LAST_COL);
            eof     <= (col_cnt == LAST_COL) && (row_cnt == LAST_ROW);
            if (col_cnt == LAST_COL) begin
               col_cnt <= '0;
               row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + RW'(1);
            end else begin
               col_cnt <= col_cnt + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_window_sum_5x5.sv
// Bench for window_sum_5x5: three instances (SHIFT 0, 1, 8) share one input stream.
// A delay-line reference computes sums arithmetically and tracks output position by count.
// Table vectors and hand sequences cover saturation, floor shift, framing and reset.
module tb_window_sum_5x5;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int DW = 12;
   localparam int OW = 16;
   localparam int SH [3] = '{0, 1, 8};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic window_valid = 1'b0;
   logic signed [DW-1:0] window [5][5];

   logic signed [OW-1:0] so  [3];
   logic                 sv  [3];
   logic                 st  [3];
   logic                 sof [3];
   logic                 eol [3];
   logic                 eof [3];
   logic [2:0]           col [3];
   logic [2:0]           row [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         window_sum_5x5 #(
            .WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .OUT_WIDTH(OW), .SHIFT(SH[g])
         ) dut (
            .clk(clk), .rst(rst), .window(window), .window_valid(window_valid),
            .sum_out(so[g]), .sum_valid(sv[g]), .sat(st[g]),
            .out_col(col[g]), .out_row(row[g]),
            .sof(sof[g]), .eol(eol[g]), .eof(eof[g])
         );
      end
   endgenerate

   task automatic chk(input string name, input int idx, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, idx, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int tap(input int i);
`ifdef WINDOW_SUM_WEIGHT_EN
      return (i == 2) ? 6 : ((i == 1 || i == 3) ? 4 : 1);
`else
      return (i >= 0) ? 1 : 1;
`endif
   endfunction

   function automatic longint raw_sum();
      longint s = 0;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            s += longint'(tap(i) * tap(j)) * longint'(window[i][j]);
      return s;
   endfunction

   function automatic longint shaped(input longint raw, input int sh);
      longint t = raw >>> sh;
      if (t > 32767)  return 32767;
      if (t < -32768) return -32768;
      return t;
   endfunction

   function automatic bit clipped(input longint raw, input int sh);
      longint t = raw >>> sh;
      return (t > 32767) || (t < -32768);
   endfunction

   // Input history: index 0 = previous cycle, 2 = three cycles back.
   bit     h_vld [3] = '{0, 0, 0};
   bit     h_rst [3] = '{1, 1, 1};
   longint h_raw [3] = '{0, 0, 0};

   initial begin
      int     k;
      bit     e_sv, e_sof, e_eol, e_eof;
      longint e_so [3];
      bit     e_st [3];
      int     e_col, e_row;
      k = 0; e_sv = 0; e_sof = 0; e_eol = 0; e_eof = 0; e_col = 0; e_row = 0;
      for (int i = 0; i < 3; i++) begin e_so[i] = 0; e_st[i] = 0; end
      forever begin
         @(negedge clk);
         if (h_rst[0]) begin
            k = 0; e_sv = 0; e_sof = 0; e_eol = 0; e_eof = 0; e_col = 0; e_row = 0;
            for (int i = 0; i < 3; i++) begin e_so[i] = 0; e_st[i] = 0; end
         end else if (h_vld[2] && !h_rst[2] && !h_rst[1]) begin
            e_sv  = 1;
            e_col = k % (W - 4);
            e_row = (k / (W - 4)) % (H - 4);
            e_sof = (e_col == 0) && (e_row == 0);
            e_eol = (e_col == W - 5);
            e_eof = e_eol && (e_row == H - 5);
            for (int i = 0; i < 3; i++) begin
               e_so[i] = shaped(h_raw[2], SH[i]);
               e_st[i] = clipped(h_raw[2], SH[i]);
            end
            k++;
         end else begin
            e_sv = 0;
         end
         for (int i = 0; i < 3; i++) begin
            chk("sb_valid", i, longint'(sv[i]), longint'(e_sv));
            chk("sb_sum",   i, longint'(so[i]), e_so[i]);
            chk("sb_sat",   i, longint'(st[i]), longint'(e_st[i]));
            chk("sb_sof",   i, longint'(sof[i]), longint'(e_sof));
            chk("sb_eol",   i, longint'(eol[i]), longint'(e_eol));
            chk("sb_eof",   i, longint'(eof[i]), longint'(e_eof));
            chk("sb_col",   i, longint'(col[i]), longint'(e_col));
            chk("sb_row",   i, longint'(row[i]), longint'(e_row));
         end
         for (int i = 2; i > 0; i--) begin
            h_vld[i] = h_vld[i-1]; h_rst[i] = h_rst[i-1]; h_raw[i] = h_raw[i-1];
         end
         h_vld[0] = window_valid;
         h_rst[0] = rst;
         h_raw[0] = raw_sum();
      end
   end

   // ---------------- frame monitor ----------------
   bit mon_en = 0;
   int n_out = 0, n_sof = 0, n_eol = 0, n_eof = 0;
   int last_col = -1, last_row = -1, last_sof = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && sv[0]) begin
            n_out++;
            if (sof[0]) n_sof++;
            if (eol[0]) begin
               n_eol++;
               chk("eol_col", 0, longint'(col[0]), 3);
            end
            if (eof[0]) begin
               n_eof++;
               chk("eof_col", 0, longint'(col[0]), 3);
               chk("eof_row", 0, longint'(row[0]), 3);
            end
            last_col = int'(col[0]);
            last_row = int'(row[0]);
            last_sof = int'(sof[0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   // mode 0: every element = val; 1: only centre = val; 2: random elements
   task automatic drive(input bit v, input bit r, input int mode, input int val);
      @(posedge clk);
      #1;
      rst = r;
      window_valid = v;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            case (mode)
               0:       window[i][j] = DW'(val);
               1:       window[i][j] = (i == 2 && j == 2) ? DW'(val) : '0;
               default: window[i][j] = DW'($urandom);
            endcase
   endtask

   typedef struct {
      int mode;
      int val;
      int e [3];
      bit s [3];
   } vec_t;

   vec_t tbl [8];

   initial begin
`ifdef WINDOW_SUM_WEIGHT_EN
      tbl[0] = '{0, 1,     '{256, 128, 1},          '{0, 0, 0}};
      tbl[1] = '{0, 2047,  '{32767, 32767, 2047},   '{1, 1, 0}};
      tbl[2] = '{0, -2048, '{-32768, -32768, -2048},'{1, 1, 0}};
      tbl[3] = '{1, -5,    '{-180, -90, -1},        '{0, 0, 0}};
      tbl[4] = '{0, 0,     '{0, 0, 0},              '{0, 0, 0}};
      tbl[5] = '{0, -1,    '{-256, -128, -1},       '{0, 0, 0}};
      tbl[6] = '{1, 2047,  '{32767, 32767, 287},    '{1, 1, 0}};
      tbl[7] = '{0, 1311,  '{32767, 32767, 1311},   '{1, 1, 0}};
`else
      tbl[0] = '{0, 1,     '{25, 12, 0},            '{0, 0, 0}};
      tbl[1] = '{0, 2047,  '{32767, 25587, 199},    '{1, 0, 0}};
      tbl[2] = '{0, -2048, '{-32768, -25600, -200}, '{1, 0, 0}};
      tbl[3] = '{1, -5,    '{-5, -3, -1},           '{0, 0, 0}};
      tbl[4] = '{0, 0,     '{0, 0, 0},              '{0, 0, 0}};
      tbl[5] = '{0, -1,    '{-25, -13, -1},         '{0, 0, 0}};
      tbl[6] = '{1, 2047,  '{2047, 1023, 7},        '{0, 0, 0}};
      tbl[7] = '{0, 1311,  '{32767, 16387, 128},    '{1, 0, 0}};
`endif
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            window[i][j] = '0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 0, longint'(sv[0]), 0);
      chk("rst_sum",   0, longint'(so[0]), 0);
      chk("rst_sat",   0, longint'(st[0]), 0);
      chk("rst_col",   0, longint'(col[0]), 0);
      chk("rst_row",   0, longint'(row[0]), 0);
      chk("rst_sof",   0, longint'(sof[0]), 0);
      drive(0, 0, 0, 0);

      // single-pulse table vectors: output must appear exactly 3 cycles later
      for (int t = 0; t < 8; t++) begin
         drive(1, 0, tbl[t].mode, tbl[t].val);
         repeat (3) drive(0, 0, 0, 0);
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            chk("tbl_valid", t * 3 + i, longint'(sv[i]), 1);
            chk("tbl_sum",   t * 3 + i, longint'(so[i]), longint'(tbl[t].e[i]));
            chk("tbl_sat",   t * 3 + i, longint'(st[i]), longint'(tbl[t].s[i]));
         end
      end

      // reset one cycle after two valid inputs: both results discarded
      drive(1, 0, 0, 3);
      drive(1, 0, 0, 4);
      drive(0, 1, 0, 0);
      for (int n = 0; n < 6; n++) begin
         drive(0, 0, 0, 0);
         @(negedge clk);
         chk("rst_drop", n, longint'(sv[0]), 0);
      end
      drive(1, 0, 0, 1);
      repeat (3) drive(0, 0, 0, 0);
      @(negedge clk);
      chk("post_rst_valid", 0, longint'(sv[0]), 1);
      chk("post_rst_sof",   0, longint'(sof[0]), 1);
      chk("post_rst_col",   0, longint'(col[0]), 0);
      chk("post_rst_row",   0, longint'(row[0]), 0);

      // full 4x4 output frame with random gaps, then one more to see the wrap
      drive(0, 1, 0, 0);
      drive(0, 0, 0, 0);
      mon_en = 1;
      for (int n = 0; n < 16; n++) begin
         drive(1, 0, 2, 0);
         repeat ($urandom_range(0, 3)) drive(0, 0, 0, 0);
      end
      repeat (3) drive(0, 0, 0, 0);
      drive(1, 0, 2, 0);
      repeat (5) drive(0, 0, 0, 0);
      @(negedge clk);
      mon_en = 0;
      chk("frame_outputs", 0, n_out, 17);
      chk("frame_sof",     0, n_sof, 2);
      chk("frame_eol",     0, n_eol, 4);
      chk("frame_eof",     0, n_eof, 1);
      chk("wrap_col",      0, last_col, 0);
      chk("wrap_row",      0, last_row, 0);
      chk("wrap_sof",      0, last_sof, 1);

      // random traffic: gaps, extremes and occasional resets
      for (int n = 0; n < 2000; n++) begin
         case ($urandom_range(0, 5))
            0:       drive(1'($urandom), ($urandom_range(0, 79) == 0), 0, 2047);
            1:       drive(1'($urandom), ($urandom_range(0, 79) == 0), 0, -2048);
            2:       drive(1'($urandom), ($urandom_range(0, 79) == 0), 1, int'($urandom_range(0, 4095)) - 2048);
            default: drive(1'($urandom), ($urandom_range(0, 79) == 0), 2, 0);
         endcase
      end
      repeat (6) drive(0, 0, 0, 0);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
